student_tlul_mem_device: RTL and testbench

- TL-UL device (responder) backed by a word-addressed internal memory. It is the far end of the bus transactions issued by the DMA and other TL-UL hosts.
- Accepts Get / PutFullData / PutPartialData on channel A and returns in-order AccessAckData / AccessAck on channel D.
- Latency and outstanding depth are configurable, so the team can exercise host-side back-pressure and pipelining (e.g. DMA memset/memcpy) against a realistic target.

---
 rtl/student_tlul_mem_device.sv | 207 ++++++++++++++++++++
 tb/tb_student_tlul_mem_device.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_tlul_mem_device.sv
// TL-UL memory responder with an in-order response queue, configurable latency and depth.
// Optional macro STUDENT_TLUL_MEM_STALL_EN adds LFSR-driven pseudo-random a_ready back-pressure.
package tlul_pkg;
    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module student_tlul_mem_device #(
    parameter int unsigned Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    output logic [15:0]        err_cnt_o
);
    import tlul_pkg::*;

    localparam int unsigned IdxW    = $clog2(Depth);
    localparam logic [2:0]  MaxOutS = 3'(MaxOutstanding);
    localparam logic [1:0]  LoadCnt = 2'(Latency - 1);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    logic [31:0]     mem_r [Depth];
    rsp_t            rsp_r [4];
    logic [1:0]      cnt_r [4];
    logic [1:0]      wr_ptr_r;
    logic [1:0]      rd_ptr_r;
    logic [2:0]      count_r;
    logic            a_ready_r;
    logic [15:0]     err_cnt_r;

    logic            borrow_s;
    logic [31:0]     offset_s;
    logic [IdxW-1:0] idx_s;
    logic            op_err_s;
    logic            req_err_s;
    logic            is_get_s;
    logic            accept_s;
    logic            mem_wr_s;
    logic            d_valid_s;
    logic            pop_s;
    logic [2:0]      count_next_s;
    logic            a_ready_next_s;
    logic            stall_s;
    rsp_t            new_rsp_s;

    // Queue slots are used 0..MaxOutstanding-1 in ring order.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if ({1'b0, p} == (MaxOutS - 3'd1)) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

`ifdef STUDENT_TLUL_MEM_STALL_EN
    logic [7:0] lfsr_r;
    logic [7:0] lfsr_next_s;

    assign lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    assign stall_s     = lfsr_next_s[0];

    // Free-running back-pressure LFSR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end
`else
    assign stall_s = 1'b0;
`endif

    // Request decode, response formation and queue occupancy bookkeeping.
    always_comb begin
        {borrow_s, offset_s} = {1'b0, tl_i.a_address} - {1'b0, BaseAddr};
        idx_s    = offset_s[IdxW+1:2];
        op_err_s = 1'b1;
        case (tl_i.a_opcode)
            OpGet:        op_err_s = 1'b0;
            OpPutFull:    op_err_s = (tl_i.a_mask != 4'hF);
            OpPutPartial: op_err_s = 1'b0;
            default:      op_err_s = 1'b1;
        endcase
        req_err_s = borrow_s | (|offset_s[31:IdxW+2]) | (offset_s[1:0] != 2'b00)
                  | (tl_i.a_size > 2'd2) | op_err_s;
        is_get_s  = (tl_i.a_opcode == OpGet);
        accept_s  = tl_i.a_valid & a_ready_r;
        mem_wr_s  = accept_s & ~req_err_s & ~is_get_s;

        new_rsp_s.opcode = is_get_s ? OpAccessAckData : OpAccessAck;
        new_rsp_s.size   = tl_i.a_size;
        new_rsp_s.source = tl_i.a_source;
        new_rsp_s.error  = req_err_s;
        if (is_get_s && !req_err_s) begin
            new_rsp_s.data = mem_r[idx_s];
        end else begin
            new_rsp_s.data = 32'h0;
        end

        d_valid_s      = (count_r != 3'd0) && (cnt_r[rd_ptr_r] == 2'd0);
        pop_s          = d_valid_s & tl_i.d_ready;
        count_next_s   = count_r + {2'b00, accept_s} - {2'b00, pop_s};
        // Registered ready: a retire this cycle only opens the door next cycle.
        a_ready_next_s = (count_next_s < MaxOutS) & ~stall_s;
    end

    // Byte-masked memory write at the A-handshake edge; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (mem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (tl_i.a_mask[b]) begin
                    mem_r[idx_s][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                end
            end
        end
    end

    // Response queue, countdowns, ready register and error counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                rsp_r[i] <= '0;
                cnt_r[i] <= 2'd0;
            end
            wr_ptr_r  <= 2'd0;
            rd_ptr_r  <= 2'd0;
            count_r   <= 3'd0;
            a_ready_r <= 1'b1;
            err_cnt_r <= 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cnt_r[i] != 2'd0) begin
                    cnt_r[i] <= cnt_r[i] - 2'd1;
                end
            end
            if (accept_s) begin
                rsp_r[wr_ptr_r] <= new_rsp_s;
                cnt_r[wr_ptr_r] <= LoadCnt;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (accept_s && req_err_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
            count_r   <= count_next_s;
            a_ready_r <= a_ready_next_s;
        end
    end

    // The head entry drives channel D; it only moves on a D-handshake.
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_s;
        tl_o.d_opcode = rsp_r[rd_ptr_r].opcode;
        tl_o.d_param  = 3'd0;
        tl_o.d_size   = rsp_r[rd_ptr_r].size;
        tl_o.d_source = rsp_r[rd_ptr_r].source;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = rsp_r[rd_ptr_r].data;
        tl_o.d_error  = rsp_r[rd_ptr_r].error;
        tl_o.a_ready  = a_ready_r;
    end

    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_student_tlul_mem_device.sv
// Bench for student_tlul_mem_device: two instances (Latency 1/Max 2 and Latency 3/Max 4)
// share one stimulus stream and are checked each cycle against a transaction-level model.
module tb_student_tlul_mem_device;
    import tlul_pkg::*;

    logic        clk;
    logic        rst_ni;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o [2];
    logic [15:0] err_cnt [2];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        int          rdy;
    } exp_t;

    int          lat_m  [2] = '{1, 3};
    int          maxo_m [2] = '{2, 4};
    exp_t        mq     [2][8];
    int          mq_n   [2];
    logic [31:0] mem_m  [2][1024];
    int          err_m  [2];
    bit          acc_last [2];
    int          acc_tot  [2];
    int          cyc;
    int          n_vec;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    student_tlul_mem_device #(
        .Depth(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(2)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o[0]), .err_cnt_o(err_cnt[0])
    );

    student_tlul_mem_device #(
        .Depth(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(4)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o[1]), .err_cnt_o(err_cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one accepted request: decode rules, memory effect, queued response.
    task automatic model_accept(input int i, input logic [2:0] op, input logic [1:0] sz,
                                input logic [7:0] src, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data);
        exp_t        e;
        logic        err;
        logic [31:0] w;
        int          idx;
        idx = int'(addr >> 2);
        err = (addr >= 32'h1000) || (addr[1:0] != 2'b00) || (sz > 2'd2)
           || !(op == 3'd0 || op == 3'd1 || op == 3'd4)
           || (op == 3'd0 && mask != 4'hF);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.sz   = sz;
        e.src  = src;
        e.err  = err;
        e.rdy  = cyc + lat_m[i];
        e.data = 32'h0;
        if (!err && op == 3'd4) e.data = mem_m[i][idx];
        if (!err && op != 3'd4) begin
            w = mem_m[i][idx];
            for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
            mem_m[i][idx] = w;
        end
        if (err && err_m[i] < 65535) err_m[i]++;
        mq[i][mq_n[i]] = e;
        mq_n[i]++;
    endtask

    // One clock cycle: drive, compare both instances at the falling edge, advance the model.
    task automatic step(input logic av, input logic [2:0] op, input logic [1:0] sz,
                        input logic [7:0] src, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic dr);
        logic  ear;
        logic  edv;
        string sfx;
        tl_i.a_valid   = av;
        tl_i.a_opcode  = op;
        tl_i.a_size    = sz;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.d_ready   = dr;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sfx = (i == 0) ? "_a" : "_b";
            ear = (mq_n[i] < maxo_m[i]);
            edv = (mq_n[i] > 0) && (cyc >= mq[i][0].rdy);
            check({"a_ready", sfx}, 32'(tl_o[i].a_ready), 32'(ear));
            check({"d_valid", sfx}, 32'(tl_o[i].d_valid), 32'(edv));
            if (edv) begin
                check({"d_opcode", sfx}, 32'(tl_o[i].d_opcode), 32'(mq[i][0].op));
                check({"d_data", sfx},   tl_o[i].d_data,         mq[i][0].data);
                check({"d_error", sfx},  32'(tl_o[i].d_error),  32'(mq[i][0].err));
                check({"d_source", sfx}, 32'(tl_o[i].d_source), 32'(mq[i][0].src));
                check({"d_size", sfx},   32'(tl_o[i].d_size),   32'(mq[i][0].sz));
                check({"d_param", sfx},  32'({tl_o[i].d_param, tl_o[i].d_sink}), 32'd0);
            end
            check({"err_cnt", sfx}, 32'(err_cnt[i]), 32'(err_m[i]));
            acc_last[i] = av && ear;
            if (edv && dr) begin
                for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                mq_n[i]--;
            end
            if (acc_last[i]) begin
                acc_tot[i]++;
                model_accept(i, op, sz, src, addr, mask, data);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd4, 2'd2, 8'd0, 32'h0, 4'hF, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        tl_i   = '0;
        rst_ni = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_d_valid", 32'(tl_o[i].d_valid), 32'd0);
            check("rst_a_ready", 32'(tl_o[i].a_ready), 32'd1);
            check("rst_d_data", tl_o[i].d_data, 32'h0);
            check("rst_d_fields", 32'({tl_o[i].d_opcode, tl_o[i].d_source, tl_o[i].d_error}), 32'd0);
            check("rst_err_cnt", 32'(err_cnt[i]), 32'd0);
            mq_n[i]  = 0;
            err_m[i] = 0;
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n;
        int          r;
        int          w;
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [3:0]  mask;
        logic [31:0] addr;
        n_vec  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst_ni = 1'b1;
        tl_i   = '0;
        for (int i = 0; i < 2; i++) begin
            mq_n[i] = 0; err_m[i] = 0; acc_tot[i] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Define every word the bench will read: 0..15 and the last word 1023.
        for (int k = 0; k <= 16; k++) begin
            w = (k == 16) ? 1023 : k;
            step(1'b1, OpPutFull, 2'd2, 8'(k), 32'(w * 4), 4'hF, $urandom, 1'b1);
        end
        idle(4);

        // Put then Get
        step(1'b1, OpPutFull, 2'd2, 8'd1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        step(1'b1, OpGet, 2'd2, 8'd3, 32'h10, 4'hF, 32'h0, 1'b1);
        check("pg_valid", 32'(tl_o[0].d_valid), 32'd1);
        check("pg_data", tl_o[0].d_data, 32'hDEADBEEF);
        check("pg_source", 32'(tl_o[0].d_source), 32'd3);
        idle(4);

        // Partial write
        step(1'b1, OpPutFull, 2'd2, 8'd4, 32'h20, 4'hF, 32'h11223344, 1'b1);
        step(1'b1, OpPutPartial, 2'd2, 8'd5, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b1);
        step(1'b1, OpGet, 2'd2, 8'd6, 32'h20, 4'hF, 32'h0, 1'b1);
        check("partial_data", tl_o[0].d_data, 32'h11BB33DD);
        idle(4);

        // Error cases
        step(1'b1, OpGet, 2'd2, 8'd7, 32'h1000, 4'hF, 32'h0, 1'b1);
        step(1'b1, OpGet, 2'd2, 8'd8, 32'h2, 4'hF, 32'h0, 1'b1);
        step(1'b1, 3'd5, 2'd2, 8'd9, 32'h10, 4'hF, 32'h0, 1'b1);
        step(1'b1, OpPutFull, 2'd2, 8'd10, 32'h10, 4'h3, 32'h12345678, 1'b1);
        idle(4);
        check("err_cnt4_a", 32'(err_cnt[0]), 32'd4);
        check("err_cnt4_b", 32'(err_cnt[1]), 32'd4);
        step(1'b1, OpGet, 2'd2, 8'd11, 32'h10, 4'hF, 32'h0, 1'b1);
        check("err_nowrite", tl_o[0].d_data, 32'hDEADBEEF);
        idle(4);

        // Back-pressure with d_ready held low
        step(1'b1, OpGet, 2'd2, 8'd1, 32'h4, 4'hF, 32'h0, 1'b0);
        step(1'b1, OpGet, 2'd2, 8'd2, 32'h8, 4'hF, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, OpGet, 2'd2, 8'd3, 32'hC, 4'hF, 32'h0, 1'b0);
        n = 0;
        do begin
            step(1'b1, OpGet, 2'd2, 8'd3, 32'hC, 4'hF, 32'h0, 1'b1);
            n++;
        end while (!acc_last[0] && n < 10);
        check("bp_accept_delay", 32'(n), 32'd2);
        idle(10);

        // Back-to-back streaming
        acc_tot[0] = 0;
        acc_tot[1] = 0;
        for (int k = 0; k < 8; k++) step(1'b1, OpGet, 2'd2, 8'(k), 32'(k * 4), 4'hF, 32'h0, 1'b1);
        check("stream_acc_a", 32'(acc_tot[0]), 32'd8);
        check("stream_acc_b", 32'(acc_tot[1]), 32'd8);
        idle(8);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            r    = $urandom_range(0, 9);
            w    = $urandom_range(0, 16);
            addr = (w == 16) ? 32'hFFC : 32'(w * 4);
            sz   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            mask = 4'($urandom_range(0, 15));
            if (r <= 3)      op = OpGet;
            else if (r <= 5) begin op = OpPutFull; mask = 4'hF; end
            else if (r <= 7) op = OpPutPartial;
            else if (r == 8) op = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'(5 + $urandom_range(0, 2));
            else             op = OpPutFull;
            case ($urandom_range(0, 9))
                0:       addr = addr | 32'($urandom_range(1, 3));
                1:       addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
                default: addr = addr;
            endcase
            step(1'($urandom_range(0, 3) != 0), op, sz, 8'($urandom), addr, mask, $urandom,
                 1'($urandom_range(0, 9) < 7));
        end
        idle(8);

        // Reset with responses queued
        step(1'b1, OpGet, 2'd2, 8'd1, 32'h4, 4'hF, 32'h0, 1'b0);
        step(1'b1, OpGet, 2'd2, 8'd2, 32'h8, 4'hF, 32'h0, 1'b0);
        do_reset();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
